regfile_xfer_ctrl: RTL and testbench

Command sequencer for the 16x32 register file. The file has one combinational read port (A) and one write port (C). This block turns single commands into timed A-select/C-select/write sequences: MOVE, SWAP, LOAD-immediate, range FILL. It sits between the control unit and the register file, owns the file's A/C ports while busy, and makes multi-register operations atomic from the requester's view.

---
 rtl/rfx_pkg.sv | 10 +
 rtl/regfile_xfer_fill_cnt.sv | 19 +
 rtl/regfile_xfer_ctrl.sv | 100 ++++++++++
 tb/tb_regfile_xfer_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfx_pkg.sv
// rfx_pkg: op encodings, FSM states and default widths shared by regfile_xfer_ctrl
package rfx_pkg;
  localparam int RFX_DATA_W = 32;
  localparam int RFX_ADDR_W = 4;
  localparam logic [1:0] RFX_OP_MOVE  = 2'b00;
  localparam logic [1:0] RFX_OP_SWAP  = 2'b01;
  localparam logic [1:0] RFX_OP_LOADI = 2'b10;
  localparam logic [1:0] RFX_OP_FILL  = 2'b11;
  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, FILLW} rfx_state_e;
endpackage

// File: rtl/regfile_xfer_fill_cnt.sv
// regfile_xfer_fill_cnt: loadable wrap-around fill address counter with a last-address flag
module regfile_xfer_fill_cnt #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic [ADDR_W-1:0] last_val,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en) cnt <= cnt + 1'b1;
  assign last = cnt == last_val;
endmodule

// File: rtl/regfile_xfer_ctrl.sv
// regfile_xfer_ctrl: sequences MOVE/SWAP/LOADI/FILL commands onto the register file A/C ports
// Define RFX_R0_PROTECT_EN to make r0 read-only and flag MOVE/SWAP/LOADI attempts on it via out_err
module regfile_xfer_ctrl
  import rfx_pkg::*;
#(
  parameter int DATA_W = RFX_DATA_W,
  parameter int ADDR_W = RFX_ADDR_W
) (
  input  logic              in_clk,
  input  logic              in_clr_n,
  input  logic              in_cmd_valid,
  output logic              out_cmd_ready,
  input  logic [1:0]        in_cmd_op,
  input  logic [ADDR_W-1:0] in_cmd_ra,
  input  logic [ADDR_W-1:0] in_cmd_rb,
  input  logic [DATA_W-1:0] in_cmd_imm,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_err,
  output logic [ADDR_W-1:0] out_rf_Aselect,
  input  logic [DATA_W-1:0] in_rf_Adata,
  output logic [ADDR_W-1:0] out_rf_Cselect,
  output logic [DATA_W-1:0] out_rf_Cdata,
  output logic              out_rf_write
);
  rfx_state_e state, nxt;
  logic [1:0] op;
  logic [ADDR_W-1:0] ra, rb, cnt;
  logic [DATA_W-1:0] imm, tmp0, tmp1;
  logic accept, last, wr_cyc, done_d;
  assign out_cmd_ready = state == IDLE;
  assign out_busy = !out_cmd_ready;
  assign accept = in_cmd_valid && out_cmd_ready;
  always_ff @(posedge in_clk or negedge in_clr_n)
    if (!in_clr_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (in_cmd_valid) nxt = in_cmd_op == RFX_OP_LOADI ? WR0 : in_cmd_op == RFX_OP_FILL ? FILLW : RD0;
      RD0: nxt = op == RFX_OP_SWAP ? RD1 : WR0;
      RD1: nxt = WR0;
      WR0: nxt = op == RFX_OP_SWAP ? WR1 : IDLE;
      WR1: nxt = IDLE;
      FILLW: nxt = last ? IDLE : FILLW;
      default: nxt = IDLE;
    endcase
  end
  // SWAP writes ra first (from tmp1), then rb (from tmp0)
  always_comb begin
    out_rf_Aselect = state == RD0 ? ra : state == RD1 ? rb : '0;
    out_rf_Cselect = state == WR0 ? (op == RFX_OP_MOVE ? rb : ra) : state == WR1 ? rb : state == FILLW ? cnt : '0;
    out_rf_Cdata = state == WR0 ? (op == RFX_OP_MOVE ? tmp0 : op == RFX_OP_SWAP ? tmp1 : imm) :
                   state == WR1 ? tmp0 : state == FILLW ? imm : '0;
    wr_cyc = state == WR0 || state == WR1 || state == FILLW;
    done_d = (state == WR0 && op != RFX_OP_SWAP) || state == WR1 || (state == FILLW && last);
  end
  always_ff @(posedge in_clk or negedge in_clr_n)
    if (!in_clr_n) begin
      op <= '0;
      ra <= '0;
      rb <= '0;
      imm <= '0;
      tmp0 <= '0;
      tmp1 <= '0;
      out_done <= 1'b0;
    end else begin
      if (accept) begin
        op <= in_cmd_op;
        ra <= in_cmd_ra;
        rb <= in_cmd_rb;
        imm <= in_cmd_imm;
      end
      if (state == RD0) tmp0 <= in_rf_Adata;
      if (state == RD1) tmp1 <= in_rf_Adata;
      out_done <= done_d;
    end
  regfile_xfer_fill_cnt #(.ADDR_W(ADDR_W)) u_cnt (
    .clk(in_clk),
    .rst_n(in_clr_n),
    .load(accept),
    .en(state == FILLW),
    .load_val(in_cmd_ra),
    .last_val(rb),
    .cnt(cnt),
    .last(last)
  );
`ifdef RFX_R0_PROTECT_EN
  logic err_d;
  assign err_d = done_d && (op == RFX_OP_MOVE ? rb == '0 : op == RFX_OP_SWAP ? (ra == '0 || rb == '0) :
                            op == RFX_OP_LOADI ? ra == '0 : 1'b0);
  assign out_rf_write = wr_cyc && |out_rf_Cselect;
  always_ff @(posedge in_clk or negedge in_clr_n)
    if (!in_clr_n) out_err <= 1'b0;
    else out_err <= err_d;
`else
  assign out_rf_write = wr_cyc;
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// tb_regfile_xfer_ctrl: randomized and directed checks of regfile_xfer_ctrl against a command-level register file model
module tb_regfile_xfer_ctrl;
`ifdef RFX_R0_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  logic clk = 1'b0, clr_n, cmd_valid, cmd_ready, busy, done, err, rf_write, rf_clear;
  logic [1:0] cmd_op;
  logic [3:0] cmd_ra, cmd_rb, a_sel, c_sel;
  logic [31:0] cmd_imm, a_data, c_data;
  logic [31:0] rf [16];
  logic [31:0] m [16];
  logic [35:0] obs_q[$], exp_q[$];
  int checks = 0, failures = 0, obs_lat, exp_lat;
  logic obs_err, exp_err, stray;
  logic [3:0] obs_a;

  always #5 clk = ~clk;

  regfile_xfer_ctrl dut (
    .in_clk(clk), .in_clr_n(clr_n), .in_cmd_valid(cmd_valid), .out_cmd_ready(cmd_ready),
    .in_cmd_op(cmd_op), .in_cmd_ra(cmd_ra), .in_cmd_rb(cmd_rb), .in_cmd_imm(cmd_imm),
    .out_busy(busy), .out_done(done), .out_err(err), .out_rf_Aselect(a_sel), .in_rf_Adata(a_data),
    .out_rf_Cselect(c_sel), .out_rf_Cdata(c_data), .out_rf_write(rf_write)
  );

  assign a_data = rf[a_sel];
  always @(posedge clk)
    if (rf_clear) for (int i = 0; i < 16; i++) rf[i] <= '0;
    else if (rf_write) rf[c_sel] <= c_data;

  task automatic push(input logic [3:0] a, input logic [31:0] d);
    if (!(PROT && a == 4'd0)) begin
      exp_q.push_back({a, d});
      m[a] = d;
    end
  endtask

  // command-level effect: list of (register, value) writes in order, plus latency and error
  task automatic model(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [31:0] imm);
    logic [31:0] va, vb;
    int n;
    va = m[ra];
    vb = m[rb];
    exp_q.delete();
    exp_err = 1'b0;
    case (op)
      2'd0: begin exp_lat = 2; push(rb, va); exp_err = PROT && rb == 0; end
      2'd1: begin exp_lat = 4; push(ra, vb); push(rb, va); exp_err = PROT && (ra == 0 || rb == 0); end
      2'd2: begin exp_lat = 1; push(ra, imm); exp_err = PROT && ra == 0; end
      default: begin
        n = ((int'(rb) - int'(ra)) & 15) + 1;
        exp_lat = n;
        for (int i = 0; i < n; i++) push(4'(int'(ra) + i), imm);
      end
    endcase
  endtask

  task automatic exec(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [31:0] imm);
    model(op, ra, rb, imm);
    obs_q.delete();
    obs_lat = -1;
    obs_err = 1'b0;
    stray = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 0) obs_a = a_sel;
      if (rf_write) obs_q.push_back({c_sel, c_data});
      if ((rf_write && !busy) || (err && !done) || (PROT && rf_write && c_sel == 4'd0)) stray = 1'b1;
      if (done) begin
        obs_lat = k;
        obs_err = err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic bit wr_ok();
    if (obs_q.size() != exp_q.size()) return 1'b0;
    foreach (obs_q[i]) if (obs_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit rf_ok();
    for (int i = 0; i < 16; i++) if (rf[i] !== m[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    clr_n = 1'b0; rf_clear = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0;
    for (int i = 0; i < 16; i++) m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, busy, done, err, rf_write, a_sel, c_sel, c_data} !== {1'b1, 44'd0}) begin
      failures++;
      $display("FAIL reset_outputs ready=%b busy=%b done=%b err=%b wr=%b a=%0d c=%0d cd=%h want ready=1 rest 0",
               cmd_ready, busy, done, err, rf_write, a_sel, c_sel, c_data);
    end
    @(negedge clk);
    clr_n = 1'b1; rf_clear = 1'b0;
  endtask

  task automatic test_move();
    exec(2'd2, 4'd3, 4'd0, 32'hDEADBEEF);
    exec(2'd0, 4'd3, 4'd7, 32'h0);
    checks++;
    if (obs_a !== 4'd3) begin failures++; $display("FAIL move_asel got=%0d want=3", obs_a); end
    checks++;
    if (!wr_ok() || obs_lat != 2) begin
      failures++;
      $display("FAIL move_seq writes=%0d lat=%0d want writes=%0d lat=2", obs_q.size(), obs_lat, exp_q.size());
    end
    checks++;
    if (rf[7] !== 32'hDEADBEEF) begin failures++; $display("FAIL move_r7 got=%h want=deadbeef", rf[7]); end
  endtask

  task automatic test_swap();
    exec(2'd2, 4'd2, 4'd0, 32'h11111111);
    exec(2'd2, 4'd5, 4'd0, 32'h22222222);
    exec(2'd1, 4'd2, 4'd5, 32'h0);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== {4'd2, 32'h22222222} || obs_q[1] !== {4'd5, 32'h11111111}) begin
      failures++;
      $display("FAIL swap_writes n=%0d want (2,22222222),(5,11111111)", obs_q.size());
    end
    checks++;
    if (obs_lat != 4) begin failures++; $display("FAIL swap_latency got=%0d want=4", obs_lat); end
    exec(2'd1, 4'd6, 4'd6, 32'h0);
    checks++;
    if (!wr_ok() || obs_lat != 4 || !rf_ok()) begin
      failures++;
      $display("FAIL swap_same writes=%0d lat=%0d want lat=4", obs_q.size(), obs_lat);
    end
  endtask

  task automatic test_fill();
    exec(2'd3, 4'd14, 4'd1, 32'hA5A5A5A5);
    checks++;
    if (!wr_ok() || obs_lat != exp_lat) begin
      failures++;
      $display("FAIL fill_wrap writes=%0d lat=%0d want writes=%0d lat=%0d", obs_q.size(), obs_lat, exp_q.size(), exp_lat);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL fill_done_width done=%b want=0", done); end
    exec(2'd3, 4'd9, 4'd9, 32'h5);
    checks++;
    if (!wr_ok() || obs_lat != 1) begin failures++; $display("FAIL fill_single writes=%0d lat=%0d want 1/1", obs_q.size(), obs_lat); end
    exec(2'd3, 4'd0, 4'd15, 32'h77);
    checks++;
    if (!wr_ok() || obs_lat != 16 || !rf_ok()) begin
      failures++;
      $display("FAIL fill_all writes=%0d lat=%0d want writes=%0d lat=16", obs_q.size(), obs_lat, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    model(2'd2, 4'd1, 4'd0, 32'h1);
    model(2'd2, 4'd2, 4'd0, 32'h2);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_ra = 4'd1; cmd_rb = 4'd0; cmd_imm = 32'h1;
    @(posedge clk); #1;
    checks++;
    if (!(rf_write && c_sel == 4'd1 && c_data == 32'h1)) begin
      failures++;
      $display("FAIL b2b_first wr=%b c=%0d d=%h want 1/1/1", rf_write, c_sel, c_data);
    end
    @(posedge clk); #1;
    checks++;
    if (!(done && cmd_ready)) begin failures++; $display("FAIL b2b_done done=%b ready=%b want 1/1", done, cmd_ready); end
    cmd_ra = 4'd2; cmd_imm = 32'h2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (!(rf_write && c_sel == 4'd2 && c_data == 32'h2 && !done)) begin
      failures++;
      $display("FAIL b2b_second wr=%b c=%0d d=%h done=%b want 1/2/2/0", rf_write, c_sel, c_data, done);
    end
    @(posedge clk); #1;
    checks++;
    if (!done || !rf_ok()) begin failures++; $display("FAIL b2b_end done=%b r1=%h r2=%h want 1/1/2", done, rf[1], rf[2]); end
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_ra = 4'd4; cmd_rb = 4'd9; cmd_imm = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (!(rf_write && c_sel == 4'd4)) begin failures++; $display("FAIL rst_mid_wr0 wr=%b c=%0d want 1/4", rf_write, c_sel); end
    clr_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy, done, err, rf_write, a_sel, c_sel, c_data} !== {1'b1, 44'd0}) begin
      failures++;
      $display("FAIL rst_mid_outputs ready=%b busy=%b wr=%b c=%0d cd=%h want ready=1 rest 0", cmd_ready, busy, rf_write, c_sel, c_data);
    end
    @(negedge clk);
    clr_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || !cmd_ready) bad = 1'b1;
    end
    checks++;
    if (bad || !rf_ok()) begin failures++; $display("FAIL rst_mid_after bad=%b rf_ok=%b want 0/1", bad, rf_ok()); end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [3:0] ra, rb;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      ra = 4'($urandom_range(0, 15));
      rb = (n % 5 == 0) ? ra : 4'($urandom_range(0, 15));
      exec(op, ra, rb, $urandom);
      checks++;
      if (!wr_ok() || obs_lat != exp_lat || obs_err !== exp_err || stray) begin
        failures++;
        $display("FAIL rand_cmd op=%0d ra=%0d rb=%0d writes=%0d/%0d lat=%0d/%0d err=%b/%b stray=%b",
                 op, ra, rb, obs_q.size(), exp_q.size(), obs_lat, exp_lat, obs_err, exp_err, stray);
      end
      checks++;
      if (!rf_ok()) begin failures++; $display("FAIL rand_rf op=%0d ra=%0d rb=%0d contents differ", op, ra, rb); end
      if (n % 4 == 0) begin
        @(posedge clk); #1;
        checks++;
        if (done || busy || err) begin failures++; $display("FAIL rand_idle done=%b busy=%b err=%b want 0", done, busy, err); end
      end
    end
  endtask

`ifdef RFX_R0_PROTECT_EN
  task automatic test_r0();
    exec(2'd2, 4'd0, 4'd0, 32'hFFFFFFFF);
    checks++;
    if (obs_q.size() != 0 || obs_lat != 1 || obs_err !== 1'b1 || stray) begin
      failures++;
      $display("FAIL r0_loadi writes=%0d lat=%0d err=%b want 0/1/1", obs_q.size(), obs_lat, obs_err);
    end
    exec(2'd3, 4'd15, 4'd1, 32'h3C3C3C3C);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== {4'd15, 32'h3C3C3C3C} || obs_q[1] !== {4'd1, 32'h3C3C3C3C} ||
        obs_lat != 3 || obs_err !== 1'b0) begin
      failures++;
      $display("FAIL r0_fill writes=%0d lat=%0d err=%b want 2/3/0", obs_q.size(), obs_lat, obs_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_move();
    test_swap();
    test_fill();
    test_back_to_back();
    test_reset_mid();
`ifdef RFX_R0_PROTECT_EN
    test_r0();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
